ps2_rx_filter: RTL and testbench

//  PS/2 keyboard receiver stage feeding the Proyecto_2 prevention core.
//  - Synchronises and deglitches ps2c/ps2d, deserialises 11-bit device-to-host frames and checks parity/stop.
//  - Suppresses break sequences (F0 xx) and extended prefixes (E0).
//  - Emits each valid make code on dato with a 1-cycle tick strobe.

---
 rtl/ps2_rx_filter.sv | 179 +++++++++++++++++
 tb/tb_ps2_rx_filter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_filter.sv
// PS/2 device-to-host receiver: synchronises and deglitches the line, deserialises 11-bit frames,
// drops break (F0 xx) and extended (E0) prefixes, and strobes each accepted make code out.
module ps2_rx_filter #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       ps2d_i,
  input  logic       ps2c_i,
  output logic [7:0] dato_o,
  output logic       tick_o,
  output logic       correct_o
);

  // state | meaning
  // IDLE  | waiting for a start bit (filtered clock fall with data low)
  // RX    | shifting in 8 data bits, parity and stop; timeout armed
  // DONE  | one cycle: check parity/stop and apply break/extended filtering
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RX   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int               TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       BRK_CODE = 8'hF0;
  localparam logic [7:0]       EXT_CODE = 8'hE0;

  logic                  c_sync1_q, c_sync2_q;
  logic                  d_sync1_q, d_sync2_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  fclk_q, fclk_d;
  logic                  fall;
  logic                  d_sample;

  logic [1:0]      state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            brk_q, brk_d;
  logic            ext_q, ext_d;
  logic [7:0]      dato_q, dato_d;
  logic            tick_q, tick_d;
  logic            correct_q, correct_d;

  logic [7:0]      rx_byte;
  logic            frame_ok;

  // Line conditioning runs regardless of en_i so re-enabling never sees a stale edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      c_sync1_q <= 1'b1;
      c_sync2_q <= 1'b1;
      d_sync1_q <= 1'b1;
      d_sync2_q <= 1'b1;
      filt_q    <= '1;
      fclk_q    <= 1'b1;
    end else begin
      c_sync1_q <= ps2c_i;
      c_sync2_q <= c_sync1_q;
      d_sync1_q <= ps2d_i;
      d_sync2_q <= d_sync1_q;
      filt_q    <= {filt_q[FILTER_LEN-2:0], c_sync2_q};
      fclk_q    <= fclk_d;
    end
  end

  always_comb begin
    fclk_d = fclk_q;
    if (&filt_q) begin
      fclk_d = 1'b1;
    end else if (~|filt_q) begin
      fclk_d = 1'b0;
    end
  end

  assign fall     = fclk_q & ~fclk_d;
  assign d_sample = d_sync2_q;

  // shift_q fills from the top: [7:0] data LSB first, [8] parity, [9] stop.
  assign rx_byte  = shift_q[7:0];
  assign frame_ok = (^shift_q[8:0]) & shift_q[9];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    dato_d    = dato_q;
    tick_d    = 1'b0;
    correct_d = correct_q;

    if (!en_i) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      to_cnt_d  = '0;
      brk_d     = 1'b0;
      ext_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall && !d_sample) begin
            state_d   = RX;
            bit_cnt_d = 4'd0;
            to_cnt_d  = '0;
          end
        end
        RX: begin
          if (fall) begin
            shift_d   = {d_sample, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            to_cnt_d  = '0;
            if (bit_cnt_q == 4'd9) begin
              state_d = DONE;
            end
          end else if (to_cnt_q == TO_LAST) begin
            state_d   = IDLE;
            correct_d = 1'b0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (!frame_ok) begin
            correct_d = 1'b0;
          end else begin
            correct_d = 1'b1;
            if (rx_byte == BRK_CODE) begin
              brk_d = 1'b1;
            end else if (rx_byte == EXT_CODE) begin
              ext_d = 1'b1;
            end else if (brk_q) begin
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else begin
              dato_d = rx_byte;
              tick_d = 1'b1;
              ext_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      dato_q    <= 8'h00;
      tick_q    <= 1'b0;
      correct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      dato_q    <= dato_d;
      tick_q    <= tick_d;
      correct_q <= correct_d;
    end
  end

  assign dato_o    = dato_q;
  assign tick_o    = tick_q;
  assign correct_o = correct_q;

endmodule

// File: tb/tb_ps2_rx_filter.sv
// Directed bench for ps2_rx_filter: frames are driven bit by bit, expected make codes are queued
// at send time and checked by a tick monitor.
module tb_ps2_rx_filter;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 40;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ps2d;
  logic       ps2c;
  logic [7:0] dato;
  logic       tick;
  logic       correct;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic       tick_prev = 1'b0;

  ps2_rx_filter #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .en_i     (en),
    .ps2d_i   (ps2d),
    .ps2c_i   (ps2c),
    .dato_o   (dato),
    .tick_o   (tick),
    .correct_o(correct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, observed running, expected finished");
    $fatal(1, "watchdog expired");
  end

  // Tick monitor: every tick must match the oldest queued code and last exactly one cycle.
  always @(negedge clk) begin
    if (tick) begin
      vectors++;
      assert (tick_prev === 1'b0) else begin
        miscompares++;
        $error("FAIL tick_width: observed tick high 2+ cycles, expected 1");
      end
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_tick: observed dato=%h, expected no tick", dato);
      end
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        vectors++;
        assert (dato === e) else begin
          miscompares++;
          $error("FAIL tick_dato: observed %h, expected %h", dato, e);
        end
      end
    end
    tick_prev = tick;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2d = b;
    cyc(HALF / 2);
    if (glitch) begin
      ps2c = 1'b0; cyc(1); ps2c = 1'b1; cyc(3);
    end
    ps2c = 1'b0;
    cyc(HALF / 2);
    if (glitch) begin
      ps2c = 1'b1; cyc(1); ps2c = 1'b0;
    end
    cyc(HALF / 2);
    ps2c = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ bad_par, glitch);
    send_bit(stop, glitch);
    ps2d = 1'b1;
    cyc(HALF);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
    ps2d = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    cyc(5);
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_drain: observed %0d pending ticks, expected 0", tag, exp_q.size());
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_dato, input logic e_correct);
    vectors++;
    assert (dato === e_dato) else begin
      miscompares++;
      $error("FAIL %s_dato: observed %h, expected %h", tag, dato, e_dato);
    end
    vectors++;
    assert (correct === e_correct) else begin
      miscompares++;
      $error("FAIL %s_correct: observed %b, expected %b", tag, correct, e_correct);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    ps2d  = 1'b1;
    ps2c  = 1'b1;
    cyc(5);
    check_out("reset", 8'h00, 1'b0);
    vectors++;
    assert (tick === 1'b0) else begin
      miscompares++;
      $error("FAIL reset_tick: observed %b, expected 0", tick);
    end
    rst_n = 1'b1;
    cyc(20);

    // Single make code
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("make1c");
    check_out("make1c", 8'h1C, 1'b1);

    // Break sequence is swallowed, next make goes through
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("break");
    check_out("break", 8'h1C, 1'b1);
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    drain("after_brk");
    check_out("after_brk", 8'h32, 1'b1);

    // Extended prefix is dropped, following code ticks
    exp_q.push_back(8'h75);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    drain("ext");
    check_out("ext", 8'h75, 1'b1);

    // Parity and stop errors
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    drain("bad_par");
    check_out("bad_par", 8'h75, 1'b0);
    exp_q.push_back(8'h3A);
    send_frame(8'h3A, 1'b0, 1'b1, 1'b0);
    drain("recover");
    check_out("recover", 8'h3A, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    drain("bad_stop");
    check_out("bad_stop", 8'h3A, 1'b0);

    // Glitches on the clock line, idle and mid-frame
    for (int i = 0; i < 4; i++) begin
      ps2c = 1'b0; cyc(1); ps2c = 1'b1; cyc(7);
    end
    exp_q.push_back(8'h45);
    send_frame(8'h45, 1'b0, 1'b1, 1'b1);
    drain("glitch");
    check_out("glitch", 8'h45, 1'b1);

    // Abandoned frame times out
    send_partial(8'hA5, 5);
    cyc(TIMEOUT_CYC + 50);
    check_out("timeout", 8'h45, 1'b0);
    exp_q.push_back(8'h16);
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    drain("post_to");
    check_out("post_to", 8'h16, 1'b1);

    // EN dropped mid-frame
    send_partial(8'h5A, 4);
    en = 1'b0;
    cyc(30);
    en = 1'b1;
    cyc(20);
    exp_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    drain("en_mid");
    check_out("en_mid", 8'h29, 1'b1);

    // Frames ignored while disabled; break flag cleared by disable
    en = 1'b0;
    send_frame(8'h4B, 1'b0, 1'b1, 1'b0);
    drain("en_off");
    check_out("en_off", 8'h29, 1'b1);
    en = 1'b1;
    cyc(20);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(20);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("en_brk");
    check_out("en_brk", 8'h1C, 1'b1);

    // Reset mid-frame
    send_partial(8'hC3, 3);
    rst_n = 1'b0;
    #1;
    check_out("rst_mid", 8'h00, 1'b0);
    vectors++;
    assert (tick === 1'b0) else begin
      miscompares++;
      $error("FAIL rst_mid_tick: observed %b, expected 0", tick);
    end
    ps2c = 1'b1;
    cyc(5);
    rst_n = 1'b1;
    cyc(20);
    exp_q.push_back(8'h16);
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    drain("post_rst");
    check_out("post_rst", 8'h16, 1'b1);

    cyc(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
